bubblesort_ctrl: RTL and testbench

Sequencing controller for the `bubblesort` core (49 × 8-bit elements, 392-bit flat data buses).
- Accepts unsorted elements one per handshake from a streaming requester and writes each into its core lane with a one-hot load strobe.
- Pulses `start`, then waits for completion under an optional watchdog.
- Snapshots the sorted vector and streams it back element by element.
- Replaces the free-running random stimulus around the core, giving a deterministic, host-driven path to the sorter.

---
 rtl/bubblesort_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_bubblesort_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubblesort_ctrl.sv
// bubblesort_ctrl: host-driven load / start / wait / drain sequencer for the bubblesort core.
// Optional watchdog on the WAIT state is built when BUBBLESORT_CTRL_TIMEOUT_EN is defined.
module bubblesort_ctrl #(
    parameter int N       = 49,
    parameter int W       = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           abort_req,
    output logic [N-1:0]   load_o,
    output logic [N*W-1:0] writedata_o,
    input  logic [N*W-1:0] readdata_i,
    output logic           start_o,
    input  logic           done_i,
    input  logic           interrupt_i,
    output logic           abort_o,
    output logic           busy_o,
    output logic           err_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [N-1:0]  LANE0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        DRAIN,
        ABORT
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_nxt;
    logic           ab_second;
    logic           ab_second_nxt;
    logic [N*W-1:0] snap;

    logic           abort_ok;
    logic           in_fire;
    logic           out_fire;
    logic           cmpl;
    logic           tmo;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("bubblesort_ctrl: TIMEOUT must be at least 2");
    end

    // Handshake and status outputs decode registered state only.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (idx == LAST);
    assign busy_o    = !((state == LOAD) && (idx == '0));
    assign out_data  = snap[int'(idx)*W +: W];

    // A requester abort is ignored while idle and while already aborting.
    always_comb begin
        abort_ok = 1'b0;
        unique case (state)
            LOAD:    abort_ok = abort_req && (idx != '0);
            START:   abort_ok = abort_req;
            WAIT:    abort_ok = abort_req;
            DRAIN:   abort_ok = abort_req;
            ABORT:   abort_ok = 1'b0;
            default: abort_ok = 1'b0;
        endcase
    end

    assign in_fire  = in_valid && in_ready && !abort_ok;
    assign out_fire = out_valid && out_ready;
    assign cmpl     = done_i | interrupt_i;

    // Next state and index; abort outranks completion, which outranks timeout.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        ab_second_nxt = 1'b0;
        unique case (state)
            LOAD: begin
                if (abort_ok) begin
                    state_nxt = ABORT;
                end else if (in_fire) begin
                    if (idx == LAST) begin
                        state_nxt = START;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            START: begin
                state_nxt = abort_ok ? ABORT : WAIT;
            end
            WAIT: begin
                if (abort_ok) begin
                    state_nxt = ABORT;
                end else if (cmpl) begin
                    state_nxt = DRAIN;
                end else if (tmo) begin
                    state_nxt = ABORT;
                end
            end
            DRAIN: begin
                if (abort_ok) begin
                    state_nxt = ABORT;
                end else if (out_fire) begin
                    if (idx == LAST) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            ABORT: begin
                ab_second_nxt = 1'b1;
                if (ab_second) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
                idx_nxt   = '0;
            end
        endcase
        if (state_nxt == ABORT) begin
            idx_nxt = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            idx       <= '0;
            ab_second <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            ab_second <= ab_second_nxt;
        end
    end

    // One-cycle lane strobe with the element replicated across all lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_o      <= '0;
            writedata_o <= '0;
        end else begin
            load_o <= '0;
            if (in_fire) begin
                load_o      <= LANE0 << idx;
                writedata_o <= {N{in_data}};
            end
        end
    end

    // Registered start pulse and abort strobe toward the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_o <= 1'b0;
            abort_o <= 1'b0;
        end else begin
            start_o <= (state == START) && (state_nxt == WAIT);
            abort_o <= (state_nxt == ABORT);
        end
    end

    // Capture the sorted vector on completion; drop it on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
        end else if (state == ABORT) begin
            snap <= '0;
        end else if ((state == WAIT) && !abort_ok && cmpl) begin
            snap <= readdata_i;
        end
    end

`ifdef BUBBLESORT_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wd;

    assign tmo = (wd == CW'(TIMEOUT - 1));

    // Watchdog counts cycles spent in WAIT, restarting on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (state != WAIT) begin
            wd <= '0;
        end else begin
            wd <= wd + CW'(1);
        end
    end

    // Sticky timeout flag, cleared by the first handshake of the next job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if ((state == WAIT) && !abort_ok && !cmpl && tmo) begin
            err_o <= 1'b1;
        end else if (in_fire && (idx == '0)) begin
            err_o <= 1'b0;
        end
    end
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bubblesort_ctrl.sv
// tb_bubblesort_ctrl: job table plus hand sequences against a sorting core model.
// Watchdog expectations follow BUBBLESORT_CTRL_TIMEOUT_EN.
module tb_bubblesort_ctrl;

    localparam int N   = 49;
    localparam int W   = 8;
    localparam int TMO = 64;
`ifdef BUBBLESORT_CTRL_TIMEOUT_EN
    localparam bit WD_EN    = 1'b1;
    localparam int FULL_DLY = 40;
`else
    localparam bit WD_EN    = 1'b0;
    localparam int FULL_DLY = 100;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           abort_req;
    logic [N-1:0]   load_o;
    logic [N*W-1:0] writedata_o;
    logic [N*W-1:0] readdata_i;
    logic           start_o;
    logic           done_i;
    logic           interrupt_i;
    logic           abort_o;
    logic           busy_o;
    logic           err_o;

    logic core_done;
    logic core_int;
    logic man_done;
    int   core_delay;
    bit   core_irq;

    assign done_i      = core_done | man_done;
    assign interrupt_i = core_int;

    bubblesort_ctrl #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .abort_req(abort_req),
        .load_o(load_o), .writedata_o(writedata_o), .readdata_i(readdata_i),
        .start_o(start_o), .done_i(done_i), .interrupt_i(interrupt_i),
        .abort_o(abort_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs written only by the monitor; checked by the main sequence.
    logic [63:0] load_q[$];
    int          load_cyc_q[$];
    int          wd_q[$];
    bit          rep_q[$];
    int          ovd_q[$];
    bit          ovr_q[$];
    bit          ovl_q[$];
    int          ovc_q[$];
    int          start_cyc_q[$];
    int          abort_cyc_q[$];
    bit          abort_err_q[$];
    int          out_n;
    int          mem[N];
    int          core_cnt = -1;

    // Monitor and core model: lanes, sort on start, delayed completion.
    always @(negedge clk) begin
        bit rep;
        int sq[$];
        if (!rst) begin
            core_cnt   = -1;
            core_done  = 1'b0;
            core_int   = 1'b0;
            readdata_i = '0;
        end else begin
            core_done = 1'b0;
            core_int  = 1'b0;
            if (load_o != '0) begin
                rep = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (writedata_o[k*W +: W] !== writedata_o[W-1:0]) rep = 1'b0;
                    if (load_o[k]) mem[k] = int'(writedata_o[k*W +: W]);
                end
                load_q.push_back(64'(load_o));
                load_cyc_q.push_back(cyc);
                wd_q.push_back(int'(writedata_o[W-1:0]));
                rep_q.push_back(rep);
            end
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    if (core_irq) core_int = 1'b1;
                    else core_done = 1'b1;
                    core_cnt = -1;
                end
            end
            if (start_o) begin
                start_cyc_q.push_back(cyc);
                sq = {};
                for (int k = 0; k < N; k++) sq.push_back(mem[k]);
                sq.sort();
                for (int k = 0; k < N; k++) readdata_i[k*W +: W] = W'(sq[k]);
                core_cnt = core_delay;
            end
            if (abort_o) begin
                abort_cyc_q.push_back(cyc);
                abort_err_q.push_back(err_o);
                core_cnt = -1;
            end
            if (out_valid) begin
                ovd_q.push_back(int'(out_data));
                ovr_q.push_back(out_ready);
                ovl_q.push_back(out_last);
                ovc_q.push_back(cyc);
                if (out_ready) out_n++;
            end
        end
    end

    int vec;
    int mis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int b_load, b_ov, b_start, b_abort, b_out;

    task automatic mark();
        b_load  = load_q.size();
        b_ov    = ovd_q.size();
        b_start = start_cyc_q.size();
        b_abort = abort_cyc_q.size();
        b_out   = out_n;
    endtask

    // Drive out_ready per mode until the controller is idle again.
    task automatic wait_idle(input int mode, input int lim, output bit ok);
        int g;
        ok = 1'b0;
        g  = 0;
        while (g < lim) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (g % 2 == 0);
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
            step();
            g++;
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic send_all(input int d[$]);
        foreach (d[k]) begin
            in_valid = 1'b1;
            in_data  = W'(d[k]);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_loads(input int d[$], input int n, input bit contig);
        int sz;
        sz = load_q.size() - b_load;
        chk("load_count", 64'(sz), 64'(n));
        for (int k = 0; k < n && k < sz; k++) begin
            chk("load_strobe", load_q[b_load+k], 64'(1) << k);
            chk("load_data", 64'(wd_q[b_load+k]), 64'(d[k]));
            chk("wdata_replicated", 64'(rep_q[b_load+k]), 64'd1);
        end
        if (contig && sz == n && start_cyc_q.size() > b_start) begin
            chk("load_consecutive", 64'(load_cyc_q[b_load+n-1] - load_cyc_q[b_load]), 64'(n - 1));
            chk("start_after_last_load", 64'(start_cyc_q[b_start] - load_cyc_q[b_load+n-1]), 64'd1);
        end
    endtask

    task automatic check_outs(input int s[$], input int dly);
        int got[$];
        bit lst[$];
        for (int i = b_ov; i < ovd_q.size(); i++) begin
            if (ovr_q[i]) begin
                got.push_back(ovd_q[i]);
                lst.push_back(ovl_q[i]);
            end
            if (i > b_ov && !ovr_q[i-1] && ovc_q[i] == ovc_q[i-1] + 1)
                chk("out_stable", 64'(ovd_q[i]), 64'(ovd_q[i-1]));
        end
        chk("out_count", 64'(got.size()), 64'(N));
        for (int k = 0; k < N && k < got.size(); k++) begin
            chk("out_data", 64'(got[k]), 64'(s[k]));
            chk("out_last", 64'(lst[k]), 64'(k == N - 1));
        end
        if (ovd_q.size() > b_ov && start_cyc_q.size() > b_start)
            chk("drain_latency", 64'(ovc_q[b_ov] - start_cyc_q[b_start]), 64'(dly + 1));
    endtask

    typedef struct {
        bit gaps;
        int omode;
        int delay;
        bit irq;
        int abort_at;
        int exp_loads;
        int exp_starts;
        int exp_aborts;
    } job_t;

    task automatic run_job(input job_t j, input int jn);
        int  d[$];
        int  s[$];
        int  acc;
        int  g;
        bit  take;
        bit  ok;
        mark();
        core_delay = j.delay;
        core_irq   = j.irq;
        for (int k = 0; k < N; k++)
            d.push_back(jn == 0 ? N - 1 - k : int'($urandom_range(255, 0)));
        acc = 0;
        g   = 0;
        while (acc < N && g < 2000) begin
            if (j.abort_at >= 0 && acc == j.abort_at) begin
                in_valid  = 1'b1;
                in_data   = W'(d[acc]);
                abort_req = 1'b1;
                step();
                abort_req = 1'b0;
                break;
            end
            in_valid = !(j.gaps && $urandom_range(3, 0) == 0);
            in_data  = W'(d[acc]);
            take     = in_valid && in_ready;
            step();
            if (take) acc++;
            g++;
        end
        in_valid = 1'b0;
        wait_idle(j.omode, 3000, ok);
        chk("job_finish", 64'(ok), 64'd1);
        check_loads(d, j.exp_loads, !j.gaps && j.abort_at < 0);
        chk("start_count", 64'(start_cyc_q.size() - b_start), 64'(j.exp_starts));
        chk("abort_count", 64'(abort_cyc_q.size() - b_abort), 64'(j.exp_aborts));
        if (j.abort_at < 0) begin
            s = d;
            s.sort();
            check_outs(s, j.delay);
        end else begin
            chk("abort_no_out_valid", 64'(ovd_q.size() - b_ov), 64'd0);
        end
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_err", 64'(err_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        job_t jobs[6];
        int   d[$];
        bit   ok;
        int   g;

        jobs[0] = '{0, 0, FULL_DLY, 0, -1, N,  1, 0};
        jobs[1] = '{0, 1, 20,       0, -1, N,  1, 0};
        jobs[2] = '{1, 2, 35,       1, -1, N,  1, 0};
        jobs[3] = '{0, 0, 20,       0, 10, 10, 0, 2};
        jobs[4] = '{1, 2, 7,        0, -1, N,  1, 0};
        jobs[5] = '{1, 1, 1,        1, -1, N,  1, 0};

        vec        = 0;
        mis        = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        abort_req  = 1'b0;
        man_done   = 1'b0;
        core_delay = -1;
        core_irq   = 1'b0;

        repeat (3) step();
        chk("rst_load_o", 64'(load_o), 64'd0);
        chk("rst_writedata", 64'(|writedata_o), 64'd0);
        chk("rst_start", 64'(start_o), 64'd0);
        chk("rst_abort", 64'(abort_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // Idle abort_req is ignored.
        mark();
        abort_req = 1'b1;
        step();
        abort_req = 1'b0;
        step();
        chk("idle_abort_ignored", 64'(abort_cyc_q.size() - b_abort), 64'd0);

        for (int i = 0; i < 6; i++) run_job(jobs[i], i);

        // Abort and completion in the same WAIT cycle.
        mark();
        core_delay = -1;
        d = {};
        for (int k = 0; k < N; k++) d.push_back(int'($urandom_range(255, 0)));
        send_all(d);
        g = 0;
        while (start_cyc_q.size() == b_start && g < 20) begin
            step();
            g++;
        end
        repeat (3) step();
        abort_req = 1'b1;
        man_done  = 1'b1;
        step();
        abort_req = 1'b0;
        man_done  = 1'b0;
        wait_idle(0, 100, ok);
        chk("simul_finish", 64'(ok), 64'd1);
        chk("simul_start", 64'(start_cyc_q.size() - b_start), 64'd1);
        chk("simul_abort", 64'(abort_cyc_q.size() - b_abort), 64'd2);
        chk("simul_no_out_valid", 64'(ovd_q.size() - b_ov), 64'd0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("done_outside_wait", 64'(out_valid), 64'd0);
        chk("done_outside_busy", 64'(busy_o), 64'd0);

        // Watchdog: completion never arrives.
        mark();
        core_delay = -1;
        send_all(d);
`ifdef BUBBLESORT_CTRL_TIMEOUT_EN
        wait_idle(0, 300, ok);
        chk("wd_finish", 64'(ok), 64'd1);
        chk("wd_abort_len", 64'(abort_cyc_q.size() - b_abort), 64'd2);
        if (abort_cyc_q.size() - b_abort >= 2 && start_cyc_q.size() > b_start) begin
            chk("wd_abort_start", 64'(abort_cyc_q[b_abort] - start_cyc_q[b_start]), 64'(TMO));
            chk("wd_abort_contig", 64'(abort_cyc_q[b_abort+1] - abort_cyc_q[b_abort]), 64'd1);
            chk("wd_err_with_abort", 64'(abort_err_q[b_abort]), 64'd1);
        end
        repeat (5) step();
        chk("wd_err_sticky", 64'(err_o), 64'd1);
        chk("wd_in_ready", 64'(in_ready), 64'd1);
        chk("wd_no_out_valid", 64'(ovd_q.size() - b_ov), 64'd0);
`else
        repeat (200) step();
        chk("nowd_no_abort", 64'(abort_cyc_q.size() - b_abort), 64'd0);
        chk("nowd_still_busy", 64'(busy_o), 64'd1);
        chk("nowd_err", 64'(err_o), 64'd0);
        abort_req = 1'b1;
        step();
        abort_req = 1'b0;
        wait_idle(0, 50, ok);
        chk("nowd_finish", 64'(ok), 64'd1);
        chk("nowd_abort_len", 64'(abort_cyc_q.size() - b_abort), 64'd2);
`endif

        // Reset dropped in the middle of a drain.
        mark();
        chk("err_before_job", 64'(err_o), 64'(WD_EN));
        core_delay = 10;
        core_irq   = 1'b0;
        in_valid   = 1'b1;
        in_data    = W'(d[0]);
        step();
        in_valid = 1'b0;
        chk("err_cleared_first_hs", 64'(err_o), 64'd0);
        for (int k = 1; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = W'(d[k]);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (out_n - b_out < 20 && g < 500) begin
            step();
            g++;
        end
        chk("reset_reached_elem20", 64'(out_n - b_out >= 20), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_last", 64'(out_last), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_load", 64'(load_o), 64'd0);
        chk("mid_rst_writedata", 64'(|writedata_o), 64'd0);
        chk("mid_rst_start", 64'(start_o), 64'd0);
        chk("mid_rst_abort", 64'(abort_o), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        out_ready = 1'b0;
        step();
        #3;
        rst = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_busy", 64'(busy_o), 64'd0);
        step();
        chk("rst_no_abort", 64'(abort_cyc_q.size() - b_abort), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
